// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD sequencer: FSM states,
// the power-on init command list and the command codes that need a long wait.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERON,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_t;

    localparam int          INIT_LEN  = 4;
    localparam logic [1:0]  INIT_LAST = 2'(INIT_LEN - 1);

    localparam logic [7:0]  CMD_CLEAR = 8'h01;
    localparam logic [7:0]  CMD_HOME  = 8'h02;

    localparam logic [7:0]  INIT_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines
    localparam logic [7:0]  INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0]  INIT_CLEAR    = 8'h01;
    localparam logic [7:0]  INIT_ENTRY    = 8'h06;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INIT_FUNC_SET;
            2'd1:    b = INIT_DISP_ON;
            2'd2:    b = INIT_CLEAR;
            default: b = INIT_ENTRY;
        endcase
        return b;
    endfunction

    // Clear and Home take far longer to execute than any other write.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counting phase timer. Loading T makes done assert on the T-th cycle
// after the load, so a phase that reloads on done lasts exactly T cycles.
module lcd_delay_timer #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q <= CNT_W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit bus sequencer: power-on init, then one byte per valid/ready
// handshake with RS/DATA setup, E pulse, hold and execution wait.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERON = 750000,
    parameter int T_SETUP   = 4,
    parameter int T_EN      = 12,
    parameter int T_HOLD    = 4,
    parameter int T_CMD     = 2000,
    parameter int T_CLR     = 80000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    lcd_state_t       state_q, state_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic             e_q, e_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    lcd_delay_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_POWERON))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign req_ready = (state_q == ST_IDLE) && init_done_q;

    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        data_d      = data_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            ST_POWERON: begin
                if (tmr_done) begin
                    rs_d     = 1'b0;
                    data_d   = init_byte(2'd0);
                    idx_d    = 2'd0;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP);
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_EN);
                end
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_HOLD);
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = needs_long_wait(rs_q, data_q) ? CNT_W'(T_CLR) : CNT_W'(T_CMD);
                end
            end
            ST_WAIT: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        rs_d     = 1'b0;
                        data_d   = init_byte(idx_q + 2'd1);
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_SETUP);
                    end
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    rs_d     = req_rs;
                    data_d   = req_data;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP);
                end
            end
            default: begin
                state_d = ST_POWERON;
            end
        endcase

        // E comes straight from a flop so the strobe never glitches on state decode.
        e_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_POWERON;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            e_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            e_q         <= e_d;
        end
    end

    assign init_done = init_done_q;
    assign busy      = (state_q != ST_IDLE);
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing: init sequence, character
// and command writes, back-to-back requests, and reset in the middle of a pulse.
module tb_lcd_ctrl;

    localparam int TP = 20;
    localparam int TS = 2;
    localparam int TE = 4;
    localparam int TH = 2;
    localparam int TC = 10;
    localparam int TL = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_q[$];
    bit ready_early = 1'b0;
    bit rw_seen = 1'b0;

    lcd_ctrl #(
        .T_POWERON (TP),
        .T_SETUP   (TS),
        .T_EN      (TE),
        .T_HOLD    (TH),
        .T_CMD     (TC),
        .T_CLR     (TL),
        .CNT_W     (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after posedge, so at negedge they show what the next edge samples.
    always @(negedge clk) begin
        if (!reset && req_valid && req_ready) acc_q.push_back(cyc);
        if (req_ready && !init_done) ready_early <= 1'b1;
        if (lcd_rw !== 1'b0) rw_seen <= 1'b1;
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rs, input logic [7:0] d);
        @(posedge clk);
        #1;
        req_valid = v;
        req_rs    = rs;
        req_data  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input int exp_rise, input logic [7:0] exp_d,
                             input logic exp_rs);
        int n;
        int rise;
        int width;
        logic [7:0] d;
        logic rs;
        n = 0;
        rise = -1;
        width = 0;
        d = 8'hxx;
        rs = 1'bx;
        while (lcd_e !== 1'b1 && n < 400) begin
            sample();
            n++;
        end
        if (lcd_e === 1'b1) begin
            rise = cyc;
            d = lcd_data;
            rs = lcd_rs;
            while (lcd_e === 1'b1 && width < 100) begin
                width++;
                sample();
            end
        end
        chk({tag, "_rise"}, rise, exp_rise);
        chk({tag, "_width"}, width, TE);
        chk({tag, "_data"}, {24'h0, d}, {24'h0, exp_d});
        chk({tag, "_rs"}, {31'h0, rs}, {31'h0, exp_rs});
    endtask

    task automatic wait_ready(output int t);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 400) begin
            sample();
            n++;
        end
        t = (req_ready === 1'b1) ? cyc : -1;
    endtask

    task automatic wait_accept(input int k, output int t);
        int n;
        n = 0;
        while (acc_q.size() <= k && n < 400) begin
            sample();
            n++;
        end
        t = (acc_q.size() > k) ? acc_q[k] : -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_lcd_e"}, {31'h0, lcd_e}, 32'h0);
        chk({tag, "_lcd_rs"}, {31'h0, lcd_rs}, 32'h0);
        chk({tag, "_lcd_rw"}, {31'h0, lcd_rw}, 32'h0);
        chk({tag, "_lcd_data"}, {24'h0, lcd_data}, 32'h0);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h0);
        chk({tag, "_init_done"}, {31'h0, init_done}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
    endtask

    initial begin
        int t0;
        int n;
        int t;
        int n1;
        int n2;
        int n3;
        int n4;
        int n5;

        repeat (3) sample();
        chk_reset_outputs("por");

        // Release reset with a character request already pending during init.
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        t0        = cyc;

        // Pulse pitch is TS+TE+TH+wait; the wait after Clear is TL.
        chk_pulse("init0", t0 + TP + TS, 8'h38, 1'b0);
        chk_pulse("init1", t0 + 40, 8'h0C, 1'b0);
        chk_pulse("init2", t0 + 58, 8'h01, 1'b0);
        chk_pulse("init3", t0 + 58 + TE + TH + TL + TS, 8'h06, 1'b0);

        n = 0;
        while (init_done !== 1'b1 && n < 500) begin
            sample();
            n++;
        end
        chk("init_done_cycle", (init_done === 1'b1) ? cyc : -1, t0 + 132);

        wait_accept(0, n1);
        chk("accept_first_idle", n1, t0 + 132);
        chk("ready_before_init", {31'h0, ready_early}, 32'h0);
        drive(1'b0, 1'b0, 8'h00);

        // Character 'A': E rises TS+1 after accept, ready returns after TS+TE+TH+TC.
        chk_pulse("char_41", n1 + 1 + TS, 8'h41, 1'b1);
        wait_ready(t);
        chk("ready_ret_41", t, n1 + 19);

        // Clear then Set-DDRAM back to back with req_valid held.
        drive(1'b1, 1'b0, 8'h01);
        wait_accept(1, n2);
        drive(1'b1, 1'b0, 8'h80);
        chk_pulse("clear", n2 + 3, 8'h01, 1'b0);
        wait_accept(2, n3);
        chk("b2b_accept_gap", n3, n2 + 59);
        drive(1'b0, 1'b0, 8'h00);
        chk_pulse("ddram_80", n3 + 3, 8'h80, 1'b0);
        wait_ready(t);
        chk("ready_ret_80", t, n3 + 19);

        // Character 0x01 is data, so it takes the short wait.
        drive(1'b1, 1'b1, 8'h01);
        wait_accept(3, n4);
        drive(1'b0, 1'b0, 8'h00);
        chk_pulse("char_01", n4 + 3, 8'h01, 1'b1);
        wait_ready(t);
        chk("ready_ret_char01", t, n4 + 19);

        // Reset in the middle of an E pulse.
        drive(1'b1, 1'b1, 8'h5A);
        wait_accept(4, n5);
        drive(1'b0, 1'b0, 8'h00);
        n = 0;
        while (lcd_e !== 1'b1 && n < 50) begin
            sample();
            n++;
        end
        chk("abort_pulse_seen", (lcd_e === 1'b1) ? cyc : -1, n5 + 3);
        reset = 1'b1;
        sample();
        chk_reset_outputs("abort");
        sample();

        @(posedge clk);
        #1;
        reset = 1'b0;
        t0    = cyc;
        chk_pulse("restart", t0 + TP + TS, 8'h38, 1'b0);
        chk("accepts_total", acc_q.size(), 5);
        chk("lcd_rw_never_high", {31'h0, rw_seen}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
